radix_4_ntt_intt_pe_cell: RTL and testbench

RADIX_4_NTT_INTT_PE_CELL -- requirements
Module: radix_4_ntt_intt_pe_cell

---
 rtl/ntt_pkg.sv | 37 +++
 rtl/mod_mul_q.sv | 47 ++++
 rtl/radix_4_ntt_intt_pe_cell.sv | 127 ++++++++++++
 tb/tb_radix_4_ntt_intt_pe_cell.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared constants, types and combinational modular helpers for the
// radix-4 NTT/INTT processing element.
//   N       : data width in bits
//   Q       : prime modulus 2^16 + 1
//   FOLD_W  : chunk width used by the folding reduction (Q = 2^FOLD_W + 1)
//   HI_W    : width of the top product chunk left after two folds
//   mod_add : (x + y) mod q for x, y in [0, q-1]
//   mod_sub : (x - y) mod q for x, y in [0, q-1]
package ntt_pkg;

    localparam int N      = 17;
    localparam int Q      = 65537;
    localparam int FOLD_W = 16;
    localparam int HI_W   = 2 * N - 2 * FOLD_W;

    typedef logic [N-1:0] word_t;

    typedef enum logic {
        MODE_NTT  = 1'b0,
        MODE_INTT = 1'b1
    } mode_e;

    // x + y >= q exactly when x >= q - y, so the sum never needs a carry bit:
    // either x - (q - y) or x + y already lies in [0, q-1].
    function automatic word_t mod_add(input word_t x, input word_t y, input word_t q);
        word_t gap;
        gap = q - y;
        return (x >= gap) ? (x - gap) : (x + y);
    endfunction

    // When y > x the wrapped result x + (q - y) is below q, so N bits suffice.
    function automatic word_t mod_sub(input word_t x, input word_t y, input word_t q);
        return (x >= y) ? (x - y) : (x + (q - y));
    endfunction

endpackage : ntt_pkg

// File: rtl/mod_mul_q.sv
// mod_mul_q
// Combinational modular multiplier: p_o = (x_i * y_i) mod Q.
// Ports:
//   x_i, y_i : operands in [0, Q-1]
//   p_o      : product fully reduced to [0, Q-1]
// For Q = 2^16 + 1 the 34-bit product is folded using 2^16 = -1 (mod Q):
// p = lo + mid*2^16 + hi*2^32  ==  lo - mid + hi  (mod Q).
module mod_mul_q
    import ntt_pkg::*;
#(
    parameter int N = ntt_pkg::N,
    parameter int Q = ntt_pkg::Q
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic [N-1:0] p_o
);

    localparam logic [N-1:0] QW = N'(Q);

    logic [2*N-1:0] prod;

    assign prod = {{N{1'b0}}, x_i} * {{N{1'b0}}, y_i};

    if (Q == 65537 && N == FOLD_W + 1) begin : g_fold
        logic [FOLD_W-1:0] lo;
        logic [FOLD_W-1:0] mid;
        logic [HI_W-1:0]   hi;
        logic [N-1:0]      lo_hi;
        logic [N-1:0]      lo_hi_red;

        assign lo  = prod[FOLD_W-1:0];
        assign mid = prod[2*FOLD_W-1:FOLD_W];
        assign hi  = prod[2*N-1:2*FOLD_W];

        // lo + hi is at most 2^16 + 2, so one conditional subtract brings it
        // into range before the (lo + hi) - mid step.
        assign lo_hi     = N'(lo) + N'(hi);
        assign lo_hi_red = (lo_hi >= QW) ? (lo_hi - QW) : lo_hi;
        assign p_o       = mod_sub(lo_hi_red, N'(mid), QW);
    end else begin : g_generic
        localparam logic [2*N-1:0] QP = (2 * N)'(Q);

        assign p_o = N'(prod % QP);
    end

endmodule : mod_mul_q

// File: rtl/radix_4_ntt_intt_pe_cell.sv
// radix_4_ntt_intt_pe_cell
// Two-layer radix-4 butterfly mod Q with a single output register stage.
//   inv = 0 : Cooley-Tukey (multiply before add/sub)
//   inv = 1 : Gentleman-Sande (add/sub before multiply), no 1/n scaling
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   inv             : 0 forward NTT, 1 inverse INTT
//   a0..a3          : operands in [0, Q-1]
//   tf0..tf2        : twiddle factors in [0, Q-1]
//   b0..b3          : registered results, one cycle after sampling
// Four multipliers are shared between both modes; inv steers their operands
// so the stage ordering changes without extra hardware or a pipeline bubble.
module radix_4_ntt_intt_pe_cell
    import ntt_pkg::*;
#(
    parameter int N = ntt_pkg::N,
    parameter int Q = ntt_pkg::Q
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inv,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [N-1:0] tf0,
    input  logic [N-1:0] tf1,
    input  logic [N-1:0] tf2,
    output logic [N-1:0] b0,
    output logic [N-1:0] b1,
    output logic [N-1:0] b2,
    output logic [N-1:0] b3
);

    localparam logic [N-1:0] QW = N'(Q);

    mode_e mode;

    // Stage-1 multiplier operands and products
    logic [N-1:0] s1_x0, s1_y0, s1_x1, s1_y1;
    logic [N-1:0] m0, m1;
    // Intermediate layer
    logic [N-1:0] c0, c1, c2, c3;
    // Stage-2 multiplier operands and products
    logic [N-1:0] s2_x0, s2_y0, s2_x1, s2_y1;
    logic [N-1:0] m2, m3;
    // Output register
    logic [3:0][N-1:0] b_d, b_q;

    assign mode = mode_e'(inv);

    // Stage-1 products: tf0*a2, tf0*a3 forward; (a0-a1)*tf1, (a2-a3)*tf2 inverse
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        s1_x0 = a2;
        s1_y0 = tf0;
        s1_x1 = a3;
        s1_y1 = tf0;
        if (mode == MODE_INTT) begin
            s1_x0 = mod_sub(a0, a1, QW);
            s1_y0 = tf1;
            s1_x1 = mod_sub(a2, a3, QW);
            s1_y1 = tf2;
        end
    end

    mod_mul_q #(.N(N), .Q(Q)) u_mul0 (.x_i(s1_x0), .y_i(s1_y0), .p_o(m0));
    mod_mul_q #(.N(N), .Q(Q)) u_mul1 (.x_i(s1_x1), .y_i(s1_y1), .p_o(m1));

    always_comb begin
        c0 = mod_add(a0, m0, QW);
        c1 = mod_add(a1, m1, QW);
        c2 = mod_sub(a0, m0, QW);
        c3 = mod_sub(a1, m1, QW);
        if (mode == MODE_INTT) begin
            c0 = mod_add(a0, a1, QW);
            c1 = m0;
            c2 = mod_add(a2, a3, QW);
            c3 = m1;
        end
    end

    // Stage-2 products: tf1*c1, tf2*c3 forward; (c0-c2)*tf0, (c1-c3)*tf0 inverse
    always_comb begin
        s2_x0 = c1;
        s2_y0 = tf1;
        s2_x1 = c3;
        s2_y1 = tf2;
        if (mode == MODE_INTT) begin
            s2_x0 = mod_sub(c0, c2, QW);
            s2_y0 = tf0;
            s2_x1 = mod_sub(c1, c3, QW);
            s2_y1 = tf0;
        end
    end

    mod_mul_q #(.N(N), .Q(Q)) u_mul2 (.x_i(s2_x0), .y_i(s2_y0), .p_o(m2));
    mod_mul_q #(.N(N), .Q(Q)) u_mul3 (.x_i(s2_x1), .y_i(s2_y1), .p_o(m3));

    always_comb begin
        b_d[0] = mod_add(c0, m2, QW);
        b_d[1] = mod_sub(c0, m2, QW);
        b_d[2] = mod_add(c2, m3, QW);
        b_d[3] = mod_sub(c2, m3, QW);
        if (mode == MODE_INTT) begin
            b_d[0] = mod_add(c0, c2, QW);
            b_d[1] = mod_add(c1, c3, QW);
            b_d[2] = m2;
            b_d[3] = m3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            b_q <= b_d;
        end
    end

    assign b0 = b_q[0];
    assign b1 = b_q[1];
    assign b2 = b_q[2];
    assign b3 = b_q[3];

endmodule : radix_4_ntt_intt_pe_cell

// File: tb/tb_radix_4_ntt_intt_pe_cell.sv
// Self-checking bench for radix_4_ntt_intt_pe_cell.
// Each step drives one butterfly, pushes the model result into a scoreboard
// queue, waits one rising edge and compares the registered outputs.
module tb_radix_4_ntt_intt_pe_cell;

    localparam int    NW = 17;
    localparam longint QM = 65537;

    typedef struct {
        logic [NW-1:0] b [4];
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inv;
    logic [NW-1:0] a0, a1, a2, a3;
    logic [NW-1:0] tf0, tf1, tf2;
    logic [NW-1:0] b0, b1, b2, b3;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    radix_4_ntt_intt_pe_cell #(.N(NW), .Q(65537)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .inv  (inv),
        .a0   (a0),
        .a1   (a1),
        .a2   (a2),
        .a3   (a3),
        .tf0  (tf0),
        .tf1  (tf1),
        .tf2  (tf2),
        .b0   (b0),
        .b1   (b1),
        .b2   (b2),
        .b3   (b3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint md(input longint x);
        return ((x % QM) + QM) % QM;
    endfunction

    // Reference butterfly written straight from the stage equations.
    function automatic exp_t model();
        exp_t   e;
        longint x0, x1, x2, x3, t0, t1, t2;
        longint c0, c1, c2, c3, r0, r1, r2, r3;
        x0 = longint'(a0); x1 = longint'(a1); x2 = longint'(a2); x3 = longint'(a3);
        t0 = longint'(tf0); t1 = longint'(tf1); t2 = longint'(tf2);
        if (inv == 1'b0) begin
            c0 = md(x0 + t0 * x2);
            c2 = md(x0 - t0 * x2);
            c1 = md(x1 + t0 * x3);
            c3 = md(x1 - t0 * x3);
            r0 = md(c0 + t1 * c1);
            r1 = md(c0 - t1 * c1);
            r2 = md(c2 + t2 * c3);
            r3 = md(c2 - t2 * c3);
        end else begin
            c0 = md(x0 + x1);
            c1 = md(md(x0 - x1) * t1);
            c2 = md(x2 + x3);
            c3 = md(md(x2 - x3) * t2);
            r0 = md(c0 + c2);
            r2 = md(md(c0 - c2) * t0);
            r1 = md(c1 + c3);
            r3 = md(md(c1 - c3) * t0);
        end
        e.b[0] = r0[NW-1:0];
        e.b[1] = r1[NW-1:0];
        e.b[2] = r2[NW-1:0];
        e.b[3] = r3[NW-1:0];
        return e;
    endfunction

    task automatic step(input string tag, input bit iv,
                        input int x0, input int x1, input int x2, input int x3,
                        input int t0, input int t1, input int t2);
        exp_t e;
        inv = iv;
        a0 = NW'(x0); a1 = NW'(x1); a2 = NW'(x2); a3 = NW'(x3);
        tf0 = NW'(t0); tf1 = NW'(t1); tf2 = NW'(t2);
        sb.push_back(model());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".b0"}, b0, e.b[0]);
        check({tag, ".b1"}, b1, e.b[1]);
        check({tag, ".b2"}, b2, e.b[2]);
        check({tag, ".b3"}, b3, e.b[3]);
    endtask

    task automatic known(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, ".k0"}, b0, NW'(e0));
        check({tag, ".k1"}, b1, NW'(e1));
        check({tag, ".k2"}, b2, NW'(e2));
        check({tag, ".k3"}, b3, NW'(e3));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".b0"}, b0, '0);
        check({tag, ".b1"}, b1, '0);
        check({tag, ".b2"}, b2, '0);
        check({tag, ".b3"}, b3, '0);
    endtask

    task automatic check_lt_q(input string tag);
        check({tag, ".lt0"}, NW'(b0 < NW'(QM)), NW'(1));
        check({tag, ".lt1"}, NW'(b1 < NW'(QM)), NW'(1));
        check({tag, ".lt2"}, NW'(b2 < NW'(QM)), NW'(1));
        check({tag, ".lt3"}, NW'(b3 < NW'(QM)), NW'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        inv   = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        tf0 = '0; tf1 = '0; tf2 = '0;

        // Reset state, before and across clock edges
        #2;
        check_zero("rst_init");
        a0 = NW'(5); tf0 = NW'(7);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("rst_held");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, forward
        step("fwd_a0", 1'b0, 1, 0, 0, 0, 256, 16, 4096);
        known("fwd_a0", 1, 1, 1, 1);
        step("fwd_a1", 1'b0, 0, 1, 0, 0, 256, 16, 4096);
        known("fwd_a1", 16, 65521, 4096, 61441);
        step("fwd_a2", 1'b0, 0, 0, 1, 0, 256, 16, 4096);
        known("fwd_a2", 256, 256, 65281, 65281);

        // Directed vectors, inverse (mode switches with no gap)
        step("inv_ones", 1'b1, 1, 1, 1, 1, 256, 16, 4096);
        known("inv_ones", 4, 0, 0, 0);
        step("inv_a0", 1'b1, 1, 0, 0, 0, 256, 16, 4096);
        known("inv_a0", 1, 16, 256, 4096);
        step("fwd_back", 1'b0, 1, 0, 0, 0, 256, 16, 4096);
        known("fwd_back", 1, 1, 1, 1);

        // Subtraction wrap: 0 - (Q-1) and similar edges
        step("wrap_fwd", 1'b0, 0, 0, 1, 0, 65536, 16, 4096);
        step("wrap_inv", 1'b1, 0, 65536, 0, 65536, 256, 16, 4096);
        step("zero_vs_max", 1'b1, 0, 65536, 65536, 0, 65536, 65536, 65536);

        // All lanes at Q-1
        step("max_fwd", 1'b0, 65536, 65536, 65536, 65536, 256, 16, 4096);
        check_lt_q("max_fwd");
        step("max_inv", 1'b1, 65536, 65536, 65536, 65536, 256, 16, 4096);
        check_lt_q("max_inv");
        step("max_all", 1'b0, 65536, 65536, 65536, 65536, 65536, 65536, 65536);
        check_lt_q("max_all");

        // Random in-range vectors; first half toggles inv every cycle
        for (int i = 0; i < 64; i++) begin
            step($sformatf("rnd%0d", i),
                 (i < 32) ? bit'(i % 2) : bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 65536)), int'($urandom_range(0, 65536)),
                 int'($urandom_range(0, 65536)), int'($urandom_range(0, 65536)),
                 int'($urandom_range(0, 65536)), int'($urandom_range(0, 65536)),
                 int'($urandom_range(0, 65536)));
        end

        // Mid-stream reset: outputs nonzero, then cleared without a clock edge
        step("pre_rst", 1'b0, 1, 0, 0, 0, 256, 16, 4096);
        known("pre_rst", 1, 1, 1, 1);
        a0 = NW'(3); a1 = NW'(9); a2 = NW'(11); a3 = NW'(13);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 0, 1, 0, 0, 256, 16, 4096);
        known("post_rst", 16, 65521, 4096, 61441);
        step("post_rst_inv", 1'b1, 1, 1, 1, 1, 256, 16, 4096);
        known("post_rst_inv", 4, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_radix_4_ntt_intt_pe_cell
